// File: rtl/cpu_clock_gen.sv
// cpu_clock_gen: programmable power-of-two divider for the CPU clock with a
// glitch-free stop/hold in the low phase, used for halt and single-step.
// Ports: clk_in (oscillator), arst (async reset, active-low), clk_sel (half-period
// select, H = 2^clk_sel), stop_clk (async hold request), clk_out (divided clock,
// flop-driven), stopped (clk_out is being held low by a stop request).
module cpu_clock_gen (
  input  logic       clk_in,
  input  logic       arst,
  input  logic [2:0] clk_sel,
  input  logic       stop_clk,
  output logic       clk_out,
  output logic       stopped
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic [2:0] sel_q;
  logic [2:0] sel_nxt;
  logic       clk_nxt;
  logic       stop_m;
  logic       stop_s;
  logic [7:0] half_m1;

  // Terminal count of the half-period counter, H-1 for the active select.
  assign half_m1 = (8'd1 << sel_q) - 8'd1;

  // State register, datapath flops and the stop_clk synchronizer.
  always_ff @(posedge clk_in or negedge arst) begin
    if (!arst) begin
      state   <= RUN;
      cnt     <= '0;
      sel_q   <= '0;
      clk_out <= 1'b0;
      stop_m  <= 1'b0;
      stop_s  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sel_q   <= sel_nxt;
      clk_out <= clk_nxt;
      stop_m  <= stop_clk;
      stop_s  <= stop_m;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel_q;
    clk_nxt   = clk_out;
    case (state)
      RUN: begin
        if (cnt != half_m1) begin
          cnt_nxt = cnt + 8'd1;
        end else if (stop_s && !clk_out) begin
          // The rising toggle is due: suppress it and park with cnt at H-1,
          // so a stop requested during the high phase lets it finish first.
          state_nxt = HOLD;
        end else begin
          cnt_nxt = '0;
          clk_nxt = ~clk_out;
          // New select is adopted only at the falling toggle so a ratio change
          // always starts on a full-period boundary (no runt pulses).
          if (clk_out) begin
            sel_nxt = clk_sel;
          end
        end
      end
      HOLD: begin
        // Release rises immediately on the edge that sees the request gone.
        if (!stop_s) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          clk_nxt   = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Output decode: stopped is simply the HOLD state flop.
  always_comb begin
    stopped = (state == HOLD);
  end

endmodule

// File: tb/tb_cpu_clock_gen.sv
`timescale 1ns/1ps
module tb_cpu_clock_gen;

  logic       clk_in;
  logic       arst;
  logic [2:0] clk_sel;
  logic       stop_clk;
  logic       clk_out;
  logic       stopped;

  int checks = 0;
  int errors = 0;

  cpu_clock_gen dut (
    .clk_in   (clk_in),
    .arst     (arst),
    .clk_sel  (clk_sel),
    .stop_clk (stop_clk),
    .clk_out  (clk_out),
    .stopped  (stopped)
  );

  // 2 MHz oscillator
  initial clk_in = 1'b0;
  always #250 clk_in = ~clk_in;

  // Reference model: schedule-based. It remembers the absolute edge index at
  // which the next toggle is due, and the stop request as a 2-sample history.
  int   n;
  int   m_end;
  int   m_sel;
  logic m_clk;
  logic m_stp;
  logic h1, h2;

  task automatic model_reset();
    n     = 0;
    m_end = 1;
    m_sel = 0;
    m_clk = 1'b0;
    m_stp = 1'b0;
    h1    = 1'b0;
    h2    = 1'b0;
  endtask

  task automatic model_edge();
    logic req;
    req = h2;
    h2  = h1;
    h1  = stop_clk;
    n++;
    if (m_stp) begin
      if (!req) begin
        m_clk = 1'b1;
        m_stp = 1'b0;
        m_end = n + (1 << m_sel);
      end
    end else if (n == m_end) begin
      if (req && !m_clk) begin
        m_stp = 1'b1;
      end else begin
        if (m_clk) m_sel = int'(clk_sel);
        m_clk = !m_clk;
        m_end = n + (1 << m_sel);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clk_in rising edge; outputs compared with the model 1 ns later.
  task automatic tick();
    @(posedge clk_in);
    if (arst) model_edge();
    #1;
    check_bit("clk_out_vs_model", clk_out, m_clk);
    check_bit("stopped_vs_model", stopped, m_stp);
  endtask

  // Count edges until clk_out reaches lvl (bounded).
  task automatic wait_level(input logic lvl, output int edges);
    edges = 0;
    while (clk_out !== lvl && edges < 600) begin
      tick();
      edges++;
    end
    if (clk_out !== lvl) begin
      errors++;
      $display("FAIL wait_level timeout: clk_out %0b never reached %0b", clk_out, lvl);
    end
  endtask

  // Asynchronous reset pulse starting mid-cycle; caller is just past an edge.
  task automatic do_async_reset();
    #100;
    arst = 1'b0;
    model_reset();
    #5;
    check_bit("async_rst_clk_out", clk_out, 1'b0);
    check_bit("async_rst_stopped", stopped, 1'b0);
    tick();
    #100;
    arst = 1'b1;
  endtask

  typedef struct {
    logic [2:0] sel;
    logic       stp;
    logic       exp_clk;
    logic       exp_stopped;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lo, hi, k;

    // Per-edge vectors right after reset: /2 first, then clk_sel=1 adopted
    // on the first falling edge giving a /4 clock.
    vecs[0] = '{3'd0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{3'd1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{3'd1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{3'd1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{3'd1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{3'd1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{3'd1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{3'd1, 1'b0, 1'b1, 1'b0};

    // Reset / default
    arst     = 1'b0;
    clk_sel  = 3'd0;
    stop_clk = 1'b0;
    model_reset();
    @(posedge clk_in);
    #1;
    check_bit("reset_clk_out", clk_out, 1'b0);
    check_bit("reset_stopped", stopped, 1'b0);
    #249;
    arst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      clk_sel  = vecs[i].sel;
      stop_clk = vecs[i].stp;
      tick();
      check_bit($sformatf("vec%0d_clk_out", i), clk_out, vecs[i].exp_clk);
      check_bit($sformatf("vec%0d_stopped", i), stopped, vecs[i].exp_stopped);
    end

    // Ratio sweep: each phase must last exactly 2^sel edges.
    for (int s = 0; s < 8; s++) begin
      clk_sel = 3'(s);
      wait_level(1'b1, lo);
      wait_level(1'b0, hi);
      for (int p = 0; p < 4; p++) begin
        wait_level(1'b1, lo);
        wait_level(1'b0, hi);
        check_int($sformatf("sweep_sel%0d_low", s), lo, 1 << s);
        check_int($sformatf("sweep_sel%0d_high", s), hi, 1 << s);
      end
    end

    // Mid-phase select change: high phase keeps its 8, then 2-edge phases.
    clk_sel = 3'd3;
    wait_level(1'b1, lo);
    wait_level(1'b0, hi);
    wait_level(1'b1, lo);
    check_int("midsel_low_before", lo, 8);
    tick();
    tick();
    clk_sel = 3'd1;
    wait_level(1'b0, hi);
    check_int("midsel_high_kept", hi + 2, 8);
    wait_level(1'b1, lo);
    check_int("midsel_low_new", lo, 2);
    wait_level(1'b0, hi);
    check_int("midsel_high_new", hi, 2);

    // Stop requested during the high phase
    clk_sel = 3'd2;
    wait_level(1'b1, lo);
    wait_level(1'b0, hi);
    wait_level(1'b1, lo);
    tick();
    stop_clk = 1'b1;
    wait_level(1'b0, hi);
    check_int("stop_high_len", hi + 1, 4);
    k = 0;
    while (stopped !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check_int("stop_low_edges", k, 4);
    check_bit("stop_clk_low", clk_out, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check_bit("stop_hold_clk", clk_out, 1'b0);
    check_bit("stop_hold_stopped", stopped, 1'b1);

    // Release: two synchronizer edges, then the rise on the next edge.
    stop_clk = 1'b0;
    k = 0;
    while (clk_out !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check_int("release_edges", k, 3);
    check_bit("release_stopped", stopped, 1'b0);
    wait_level(1'b0, hi);
    check_int("release_high", hi, 4);
    wait_level(1'b1, lo);
    check_int("release_low", lo, 4);

    // Async reset while clk_out is high: sel_q returns to 0 (first period /2).
    clk_sel = 3'd5;
    do_async_reset();
    tick();
    check_bit("post_rst_rise", clk_out, 1'b1);
    tick();
    check_bit("post_rst_fall", clk_out, 1'b0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 99) < 3) clk_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 2) stop_clk = ~stop_clk;
      if ($urandom_range(0, 999) == 0) do_async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
